// File: rtl/mem_system.sv
// Direct-mapped write-back, write-allocate cache: 32 lines x 4 words x 16 bits.
// Ports: clk/rst; Addr, DataIn, Rd, Wr, createdump in; DataOut, Done, Stall,
// CacheHit, err out; mem_addr, mem_wdata, mem_rd, mem_wr, mem_rdata, mem_ack
// form the word-wide backing-memory handshake.
module mem_system (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, WB2, WB3,
    FILL0, FILL1, FILL2, FILL3, CMPLT
  } state_t;

  state_t      state;
  logic [31:0] valid;
  logic [31:0] dirty;
  logic [7:0]  tags [32];
  logic [15:0] data [128];

  logic [15:0] l_addr;
  logic [15:0] l_din;
  logic        l_rd;
  logic        l_wr;

  logic [4:0]  idx;
  logic [1:0]  word;
  logic [7:0]  tag;
  logic [4:0]  l_idx;
  logic [1:0]  l_word;
  logic [7:0]  l_tag;
  logic        bad;
  logic        req;
  logic        hit;
  logic [1:0]  beat;
  logic        unused_ok;

  assign idx    = Addr[7:3];
  assign word   = Addr[2:1];
  assign tag    = Addr[15:8];
  assign l_idx  = l_addr[7:3];
  assign l_word = l_addr[2:1];
  assign l_tag  = l_addr[15:8];

  assign bad = (Rd & Wr) | (Addr[0] & (Rd | Wr));
  assign req = (Rd ^ Wr) & ~Addr[0];
  assign hit = valid[idx] && (tags[idx] == tag);

  assign unused_ok = createdump ^ l_addr[0];

  // Word within the line being transferred in WBn/FILLn.
  always_comb begin
    beat = 2'd0;
    case (state)
      WB1, FILL1: beat = 2'd1;
      WB2, FILL2: beat = 2'd2;
      WB3, FILL3: beat = 2'd3;
      default:    beat = 2'd0;
    endcase
  end

  // IDLE responses must be same-cycle, so outputs decode state and inputs.
  always_comb begin
    DataOut   = '0;
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    err       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bad) begin
            err = 1'b1;
          end else if (req && hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            if (Rd) DataOut = data[{idx, word}];
          end else if (req) begin
            Stall = 1'b1;
          end
        end
        WB0, WB1, WB2, WB3: begin
          Stall     = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = {tags[l_idx], l_idx, beat, 1'b0};
          mem_wdata = data[{l_idx, beat}];
        end
        FILL0, FILL1, FILL2, FILL3: begin
          Stall    = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = {l_tag, l_idx, beat, 1'b0};
        end
        CMPLT: begin
          Done = 1'b1;
          if (l_rd) DataOut = data[{l_idx, l_word}];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            if (Wr) begin
              data[{idx, word}] <= DataIn;
              dirty[idx]        <= 1'b1;
            end
          end else if (req) begin
            l_addr <= Addr;
            l_din  <= DataIn;
            l_rd   <= Rd;
            l_wr   <= Wr;
            // Line is invalid until the refill fully lands.
            valid[idx] <= 1'b0;
            state <= (valid[idx] && dirty[idx]) ? WB0 : FILL0;
          end
        end
        WB0, WB1, WB2, WB3: begin
          if (mem_ack) state <= state_t'(state + 4'd1);
        end
        FILL0, FILL1, FILL2, FILL3: begin
          if (mem_ack) begin
            data[{l_idx, beat}] <= mem_rdata;
            state <= state_t'(state + 4'd1);
            if (state == FILL3) begin
              valid[l_idx] <= 1'b1;
              dirty[l_idx] <= 1'b0;
              tags[l_idx]  <= l_tag;
            end
          end
        end
        CMPLT: begin
          if (l_wr) begin
            data[{l_idx, l_word}] <= l_din;
            dirty[l_idx]          <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_system.sv
// Directed bench for mem_system: vector table plus multi-cycle sequences.
// Backing memory is a sparse model whose untouched words hold addr+0x1000.
module tb_mem_system;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = '0;
  logic [15:0] DataIn = '0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic        createdump = 1'b0;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_system dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn),
    .Rd(Rd), .Wr(Wr), .createdump(createdump),
    .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0;
  int failures = 0;

  // Responder state (written only by the responder process).
  logic [15:0] mem [int];
  logic        log_wr [256];
  logic [15:0] log_a [256];
  logic [15:0] log_d [256];
  int          log_n = 0;
  int          wait_cnt = 0;
  int          resp_d = 0;
  int          both_cnt = 0;

  // Written only by the main process.
  logic [15:0] hold_addr = 16'h0001;
  int          hold_delay = 0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_rd && mem_wr) both_cnt++;
    if (!rst && (mem_rd || mem_wr)) begin
      resp_d = (mem_rd && mem_addr == hold_addr) ? hold_delay : 0;
      if (wait_cnt < resp_d) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        mem_ack = 1'b1;
        if (mem_wr) begin
          mem[int'(mem_addr[15:1])] = mem_wdata;
        end else if (mem.exists(int'(mem_addr[15:1]))) begin
          mem_rdata = mem[int'(mem_addr[15:1])];
        end else begin
          mem_rdata = mem_addr + 16'h1000;
        end
        if (log_n < 256) begin
          log_wr[log_n] = mem_wr;
          log_a[log_n]  = mem_addr;
          log_d[log_n]  = mem_wdata;
          log_n++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_dout"}, DataOut, 16'h0);
    chk({nm, "_done"}, 16'(Done), 16'h0);
    chk({nm, "_stall"}, 16'(Stall), 16'h0);
    chk({nm, "_hit"}, 16'(CacheHit), 16'h0);
    chk({nm, "_err"}, 16'(err), 16'h0);
    chk({nm, "_mrd"}, 16'(mem_rd), 16'h0);
    chk({nm, "_mwr"}, 16'(mem_wr), 16'h0);
    chk({nm, "_maddr"}, mem_addr, 16'h0);
    chk({nm, "_mwdata"}, mem_wdata, 16'h0);
  endtask

  task automatic wait_done(input string nm, output logic x_hit,
                           output logic [15:0] x_dout);
    logic got;
    got = 1'b0;
    x_hit = 1'bx;
    x_dout = 'x;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (Done) begin
        got = 1'b1;
        x_hit = CacheHit;
        x_dout = DataOut;
      end
    end
    chk({nm, "_done_seen"}, 16'(got), 16'h1);
  endtask

  task automatic access(input string nm, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] din,
                        output logic f_done, output logic f_hit,
                        output logic f_stall, output logic f_err,
                        output logic [15:0] f_dout, output logic x_hit,
                        output logic [15:0] x_dout, output int n0);
    n0 = log_n;
    @(posedge clk);
    #1;
    Rd = rd; Wr = wr; Addr = a; DataIn = din;
    @(negedge clk);
    f_done = Done; f_hit = CacheHit; f_stall = Stall;
    f_err = err; f_dout = DataOut;
    x_hit = CacheHit; x_dout = DataOut;
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0;
    if (f_stall) wait_done(nm, x_hit, x_dout);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] din;
    logic        e_err;
    logic        e_hit;
    int          e_wb;
    logic [15:0] e_wbb;
    logic [15:0] e_wbw1;
    logic [15:0] e_data;
  } vec_t;

  vec_t vt [18];

  logic        f_done, f_hit, f_stall, f_err, x_hit;
  logic [15:0] f_dout, x_dout;
  int          n0, nw, nr;
  logic        got;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0, 16'h0, 16'h1010};
    vt[1]  = '{1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'h0, 16'h0, 16'h1010};
    vt[2]  = '{1, 0, 16'h0016, 16'h0000, 0, 1, 0, 16'h0, 16'h0, 16'h1016};
    vt[3]  = '{0, 1, 16'h0012, 16'hBEEF, 0, 1, 0, 16'h0, 16'h0, 16'h0};
    vt[4]  = '{1, 0, 16'h0012, 16'h0000, 0, 1, 0, 16'h0, 16'h0, 16'hBEEF};
    vt[5]  = '{1, 0, 16'h1012, 16'h0000, 0, 0, 4, 16'h0010, 16'hBEEF,
               16'h2012};
    vt[6]  = '{1, 0, 16'h0012, 16'h0000, 0, 0, 0, 16'h0, 16'h0, 16'hBEEF};
    vt[7]  = '{1, 0, 16'hFFFE, 16'h0000, 0, 0, 0, 16'h0, 16'h0, 16'h0FFE};
    vt[8]  = '{1, 0, 16'hFFF8, 16'h0000, 0, 1, 0, 16'h0, 16'h0, 16'h0FF8};
    vt[9]  = '{1, 0, 16'h00F8, 16'h0000, 0, 0, 0, 16'h0, 16'h0, 16'h10F8};
    vt[10] = '{0, 1, 16'h0020, 16'h1234, 0, 0, 0, 16'h0, 16'h0, 16'h0};
    vt[11] = '{1, 0, 16'h0020, 16'h0000, 0, 1, 0, 16'h0, 16'h0, 16'h1234};
    vt[12] = '{1, 0, 16'h0022, 16'h0000, 0, 1, 0, 16'h0, 16'h0, 16'h1022};
    vt[13] = '{1, 1, 16'h0012, 16'hDEAD, 1, 0, 0, 16'h0, 16'h0, 16'h0};
    vt[14] = '{1, 0, 16'h0011, 16'h0000, 1, 0, 0, 16'h0, 16'h0, 16'h0};
    vt[15] = '{0, 1, 16'h0013, 16'h5555, 1, 0, 0, 16'h0, 16'h0, 16'h0};
    vt[16] = '{1, 0, 16'h0012, 16'h0000, 0, 1, 0, 16'h0, 16'h0, 16'hBEEF};
    vt[17] = '{1, 0, 16'h0010, 16'h0000, 0, 1, 0, 16'h0, 16'h0, 16'h1010};

    // Reset with a request pending: every output must read zero.
    Rd = 1'b1; Addr = 16'h0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_zero("rst");
    @(posedge clk);
    #1;
    rst = 1'b0; Rd = 1'b0;

    for (int i = 0; i < 18; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      access(nm, vt[i].rd, vt[i].wr, vt[i].a, vt[i].din,
             f_done, f_hit, f_stall, f_err, f_dout, x_hit, x_dout, n0);
      chk({nm, "_err"}, 16'(f_err), 16'(vt[i].e_err));
      if (vt[i].e_err) begin
        chk({nm, "_done"}, 16'(f_done), 16'h0);
        chk({nm, "_stall"}, 16'(f_stall), 16'h0);
        chk({nm, "_dout"}, f_dout, 16'h0);
        chk({nm, "_xfers"}, 16'(log_n - n0), 16'h0);
      end else if (vt[i].e_hit) begin
        chk({nm, "_done"}, 16'(f_done), 16'h1);
        chk({nm, "_hit"}, 16'(f_hit), 16'h1);
        chk({nm, "_stall"}, 16'(f_stall), 16'h0);
        chk({nm, "_xfers"}, 16'(log_n - n0), 16'h0);
      end else begin
        chk({nm, "_stall"}, 16'(f_stall), 16'h1);
        chk({nm, "_done"}, 16'(f_done), 16'h0);
        chk({nm, "_xhit"}, 16'(x_hit), 16'h0);
        nw = 0; nr = 0;
        for (int j = n0; j < log_n; j++) begin
          if (log_wr[j]) begin
            chk({nm, "_wb_addr"}, log_a[j], vt[i].e_wbb + 16'(2 * nw));
            if (nw == 1) chk({nm, "_wb_w1"}, log_d[j], vt[i].e_wbw1);
            nw++;
          end else begin
            chk({nm, "_fill_addr"}, log_a[j],
                {vt[i].a[15:3], 3'b000} + 16'(2 * nr));
            nr++;
          end
        end
        chk({nm, "_wb_cnt"}, 16'(nw), 16'(vt[i].e_wb));
        chk({nm, "_fill_cnt"}, 16'(nr), 16'h4);
      end
      if (vt[i].rd && !vt[i].e_err)
        chk({nm, "_data"}, x_dout, vt[i].e_data);
    end

    // No request: all status quiet.
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0010;
    @(negedge clk);
    all_zero("idle");

    // Fresh reset, then hold mem_ack off for 5 cycles in FILL1.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold_addr = 16'h0012;
    hold_delay = 5;
    @(posedge clk);
    #1;
    Rd = 1'b1; Addr = 16'h0010;
    @(negedge clk);
    chk("hold_miss_stall", 16'(Stall), 16'h1);
    @(posedge clk);
    #1;
    Rd = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 16'h0012) got = 1'b1;
    end
    chk("hold_reach_fill1", 16'(got), 16'h1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_mrd", 16'(mem_rd), 16'h1);
      chk("hold_maddr", mem_addr, 16'h0012);
      chk("hold_stall", 16'(Stall), 16'h1);
    end
    wait_done("hold", x_hit, x_dout);
    chk("hold_xhit", 16'(x_hit), 16'h0);
    chk("hold_data", x_dout, 16'h1010);
    hold_delay = 0;
    hold_addr = 16'h0001;

    // Reset in FILL2 abandons the refill; the line must miss again.
    @(posedge clk);
    #1;
    Rd = 1'b1; Addr = 16'h0044;
    @(negedge clk);
    chk("abort_miss_stall", 16'(Stall), 16'h1);
    @(posedge clk);
    #1;
    Rd = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 16'h0044) got = 1'b1;
    end
    chk("abort_reach_fill2", 16'(got), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    all_zero("abort_rst");
    rst = 1'b0;
    access("refill", 1'b1, 1'b0, 16'h0044, 16'h0,
           f_done, f_hit, f_stall, f_err, f_dout, x_hit, x_dout, n0);
    chk("refill_stall", 16'(f_stall), 16'h1);
    chk("refill_f_hit", 16'(f_hit), 16'h0);
    chk("refill_xhit", 16'(x_hit), 16'h0);
    chk("refill_data", x_dout, 16'h1044);
    chk("refill_xfers", 16'(log_n - n0), 16'h4);
    chk("refill_first", log_a[n0], 16'h0040);

    chk("one_strobe", 16'(both_cnt), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
